// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame instead of 8N1).
module uart_tx #(
  parameter int CLK_HZ = 33333333,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  // The high byte of the write data carries no meaning for the transmitter.
  logic unused_in;
  assign unused_in = ^in[15:8];

  assign bit_end = (baud_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (load) begin
            shift_q <= in[7:0];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^in[7:0];
`endif
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              // Next bit is already sitting at shift_q[1]; drive it as we shift.
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx  = tx_q;
  assign out = {busy_q, 15'b0};

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=4: random frames against a per-cycle frame model built from bit lists.
module tb_uart_tx;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;
  logic        tx;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];

  uart_tx #(.CLK_HZ(4), .BAUD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .in    (in),
    .out   (out),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One line bit held for a full bit period.
  task automatic push_bit(input logic b);
    for (int i = 0; i < DIV; i++) exp_q.push_back(b);
  endtask

  task automatic build_frame(input logic [7:0] b);
    exp_q.delete();
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i]);
`ifdef UART_TX_PARITY_EN
    push_bit(^b);
`endif
    push_bit(1'b1);
  endtask

  task automatic idle(input int n);
    load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", {15'b0, tx}, 16'h0001);
      check("idle_out", out, 16'h0000);
    end
  endtask

  // Entered at a negedge; returns at the negedge just after busy clears.
  // j1/j2: cycle indices where a stray load is driven while busy (-1 = none).
  task automatic run_frame(input logic [7:0] b, input int j1, input int j2);
    int k;
    logic e;
    build_frame(b);
    load = 1'b1;
    in   = {8'($urandom), b};
    @(negedge clk);
    load = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_tx", {15'b0, tx}, {15'b0, e});
      check("frame_busy", out, 16'h8000);
      load = (k == j1) || (k == j2);
      in   = load ? 16'h0000 : 16'($urandom);
      k++;
      @(negedge clk);
    end
    load = 1'b0;
    check("end_tx", {15'b0, tx}, 16'h0001);
    check("end_out", out, 16'h0000);
  endtask

  task automatic reset_mid_frame(input logic [7:0] b);
    build_frame(b);
    load = 1'b1;
    in   = {8'h00, b};
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 4 * DIV + 1; k++) begin
      check("pre_rst_tx", {15'b0, tx}, {15'b0, exp_q.pop_front()});
      @(negedge clk);
    end
    // Middle of data bit 3; load asserted too, reset must win.
    reset = 1'b1;
    load  = 1'b1;
    in    = 16'h00FF;
    @(negedge clk);
    check("rst_mid_tx", {15'b0, tx}, 16'h0001);
    check("rst_mid_out", out, 16'h0000);
    reset = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    check("post_rst_tx", {15'b0, tx}, 16'h0001);
    check("post_rst_out", out, 16'h0000);
    run_frame(8'h80, -1, -1);
  endtask

  initial begin
    int gap;
    int j1;
    int j2;
    reset = 1'b1;
    load  = 1'b0;
    in    = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_tx", {15'b0, tx}, 16'h0001);
    check("reset_out", out, 16'h0000);
    reset = 1'b0;
    idle(20);

    run_frame(8'h55, -1, -1);
    idle(3);

    // Stray loads at cycle 10 and on the final STOP cycle, then a back-to-back frame.
    run_frame(8'hA5, 9, NB * DIV - 1);
    run_frame(8'h01, -1, -1);
    idle(3);

    reset_mid_frame(8'h3C);
    idle(2);

    run_frame(8'h07, -1, -1);
    idle(1);
    run_frame(8'h03, -1, -1);
    idle(1);

    for (int n = 0; n < 20; n++) begin
      j1  = $urandom_range(0, NB * DIV - 1);
      j2  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB * DIV - 1)) : -1;
      run_frame(8'($urandom), j1, j2);
      gap = $urandom_range(0, 3);
      idle(gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
